// File: rtl/jelly_bean_pkg.sv
// rtl/jelly_bean_pkg.sv - jelly-bean bus types and the taste verdict rule
package jelly_bean_pkg;

  typedef enum logic [2:0] {
    NO_FLAVOR  = 3'd0,
    APPLE      = 3'd1,
    BLUEBERRY  = 3'd2,
    BUBBLE_GUM = 3'd3,
    CHOCOLATE  = 3'd4
  } flavor_e;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  typedef enum logic [1:0] {
    NO_OP = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } command_e;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    YUMMY   = 2'd1,
    YUCKY   = 2'd2
  } taste_e;

  // Raw field widths so flavor 5..7 and color 3 can be held without casting.
  typedef struct packed {
    logic [2:0] flavor;
    logic [1:0] color;
    logic       sugar_free;
    logic       sour;
  } recipe_t;

  function automatic taste_e taste_of(recipe_t r);
    if (r.flavor == NO_FLAVOR || (r.flavor == CHOCOLATE && r.sour))
      return YUCKY;
    return YUMMY;
  endfunction

endpackage

// File: rtl/jelly_bean_taste_pipe.sv
// rtl/jelly_bean_taste_pipe.sv - fixed-latency response delay line
module jelly_bean_taste_pipe #(
  parameter int LATENCY = 2,
  parameter int W       = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[LATENCY-1];

endmodule

// File: rtl/jelly_bean_taster.sv
// rtl/jelly_bean_taster.sv - jelly-bean bus responder: decode, recipe register, statistics
module jelly_bean_taster
  import jelly_bean_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         flavor,
  input  logic [1:0]         color,
  input  logic               sugar_free,
  input  logic               sour,
  input  logic [1:0]         command,
  input  logic               clr_stats,
  output logic [1:0]         taste,
  output logic               cmd_err,
  output logic [COUNT_W-1:0] yummy_cnt,
  output logic [COUNT_W-1:0] yucky_cnt
);

  recipe_t    sampled;
  recipe_t    recipe_q;
  logic       recipe_valid;
  logic       is_write;
  taste_e     write_taste;
  logic [2:0] resp;
  logic [2:0] pipe_out;
  logic       unused_recipe_bits;

  assign sampled     = '{flavor: flavor, color: color, sugar_free: sugar_free, sour: sour};
  assign is_write    = (command == WRITE);
  assign write_taste = taste_of(sampled);

  // {err, taste} launched into the delay line for the command sampled this edge.
  always_comb begin
    resp = 3'b000;
    case (command)
      READ:    if (recipe_valid) resp[1:0] = taste_of(recipe_q);
      WRITE:   resp[1:0] = write_taste;
      2'b11:   resp[2] = 1'b1;
      default: resp = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recipe_q     <= '0;
      recipe_valid <= 1'b0;
    end else if (is_write) begin
      recipe_q     <= sampled;
      recipe_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yummy_cnt <= '0;
      yucky_cnt <= '0;
    end else if (clr_stats) begin
      yummy_cnt <= '0;
      yucky_cnt <= '0;
    end else if (is_write) begin
      if (write_taste == YUMMY && yummy_cnt != '1) yummy_cnt <= yummy_cnt + COUNT_W'(1);
      if (write_taste == YUCKY && yucky_cnt != '1) yucky_cnt <= yucky_cnt + COUNT_W'(1);
    end
  end

  // color and sugar_free are kept for read-back but never steer the verdict.
  assign unused_recipe_bits = ^{recipe_q.color, recipe_q.sugar_free};

  jelly_bean_taste_pipe #(
    .LATENCY(LATENCY),
    .W      (3)
  ) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (resp),
    .dout (pipe_out)
  );

  assign taste   = pipe_out[1:0];
  assign cmd_err = pipe_out[2];

endmodule

// File: tb/tb_jelly_bean_taster.sv
// tb/tb_jelly_bean_taster.sv - directed and random checks of jelly_bean_taster
module tb_jelly_bean_taster;

  localparam int L    = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    flavor = '0;
  logic [1:0]    color = '0;
  logic          sugar_free = 1'b0;
  logic          sour = 1'b0;
  logic [1:0]    command = '0;
  logic          clr_stats = 1'b0;
  logic [1:0]    taste;
  logic          cmd_err;
  logic [CW-1:0] yummy_cnt;
  logic [CW-1:0] yucky_cnt;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  logic [2:0] hist [HMAX];
  logic       m_valid = 1'b0;
  int         m_flavor = 0;
  int         m_sour = 0;
  int         m_yummy = 0;
  int         m_yucky = 0;

  jelly_bean_taster #(.LATENCY(L), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flavor    (flavor),
    .color     (color),
    .sugar_free(sugar_free),
    .sour      (sour),
    .command   (command),
    .clr_stats (clr_stats),
    .taste     (taste),
    .cmd_err   (cmd_err),
    .yummy_cnt (yummy_cnt),
    .yucky_cnt (yucky_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] verdict(int f, int s);
    if (f == 0 || (f == 4 && s != 0)) return 2'd2;
    return 2'd1;
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_all();
    int idx;
    logic [2:0] e;
    idx = edge_n - L + 1;
    e = (idx >= 1 && idx < HMAX) ? hist[idx] : 3'b000;
    chk("taste", int'(taste), int'(e[1:0]));
    chk("cmd_err", int'(cmd_err), int'(e[2]));
    chk("yummy_cnt", int'(yummy_cnt), m_yummy);
    chk("yucky_cnt", int'(yucky_cnt), m_yucky);
  endtask

  task automatic cycle(input int cmd, input int f, input int c, input int sf, input int so, input int clr);
    logic [2:0] r;
    command    = 2'(cmd);
    flavor     = 3'(f);
    color      = 2'(c);
    sugar_free = 1'(sf);
    sour       = 1'(so);
    clr_stats  = 1'(clr);
    @(posedge clk);
    edge_n++;
    r = 3'b000;
    if (rst_n) begin
      if (cmd == 1) r = m_valid ? {1'b0, verdict(m_flavor, m_sour)} : 3'b000;
      else if (cmd == 2) r = {1'b0, verdict(f, so)};
      else if (cmd == 3) r = 3'b100;
      if (clr != 0) begin
        m_yummy = 0;
        m_yucky = 0;
      end else if (cmd == 2) begin
        if (verdict(f, so) == 2'd1 && m_yummy < CMAX) m_yummy++;
        if (verdict(f, so) == 2'd2 && m_yucky < CMAX) m_yucky++;
      end
      if (cmd == 2) begin
        m_valid  = 1'b1;
        m_flavor = f;
        m_sour   = so;
      end
    end
    if (edge_n < HMAX) hist[edge_n] = r;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < HMAX; i++) hist[i] = 3'b000;
    m_valid = 1'b0;
    m_yummy = 0;
    m_yucky = 0;
    chk("rst_taste", int'(taste), 0);
    chk("rst_cmd_err", int'(cmd_err), 0);
    chk("rst_yummy", int'(yummy_cnt), 0);
    chk("rst_yucky", int'(yucky_cnt), 0);
    repeat (hold) cycle(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) hist[i] = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset(1);

    // Scenario 1: WRITE APPLE/RED, single YUMMY pulse L cycles later.
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    cycle(2, 1, 0, 0, 0, 0);
    chk("t1_pre", int'(taste), 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t1_pulse", int'(taste), 1);
    chk("t1_yummy", int'(yummy_cnt), 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t1_after", int'(taste), 0);

    // Scenario 2: WRITE CHOCOLATE sour then READ-after-write.
    do_reset(1);
    cycle(2, 4, 1, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t2_write", int'(taste), 2);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t2_read", int'(taste), 2);
    chk("t2_yucky", int'(yucky_cnt), 1);
    chk("t2_yummy", int'(yummy_cnt), 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Scenario 3: READ with no recipe stored.
    do_reset(1);
    cycle(1, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t3_taste", int'(taste), 0);

    // Scenario 4: reserved command raises cmd_err for one cycle.
    cycle(3, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t4_err", int'(cmd_err), 1);
    chk("t4_taste", int'(taste), 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t4_err_clear", int'(cmd_err), 0);

    // Scenario 5: saturation then clear winning over a coincident WRITE.
    do_reset(1);
    repeat (5) cycle(2, 2, 1, 1, 0, 0);
    chk("t5_sat", int'(yummy_cnt), 3);
    cycle(2, 2, 1, 1, 0, 1);
    chk("t5_clear", int'(yummy_cnt), 0);

    // Scenario 6: reset right after a WRITE suppresses its pulse and the recipe.
    do_reset(1);
    cycle(2, 1, 0, 0, 0, 0);
    do_reset(1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t6_read", int'(taste), 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Random traffic with occasional resets and clears.
    do_reset(1);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 2)));
      else cycle(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
